// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and sizes for the mux scan sequencer.
package mux_scan_sequencer_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;
  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Scan request, mux select/Y and capture reporting between a controller and the sequencer.
interface mux_scan_sequencer_if;
  import mux_scan_sequencer_pkg::*;

  logic            start;
  logic            abort;
  logic [NCH-1:0]  mask;
  logic            y;
  logic            s2;
  logic            s1;
  logic            s0;
  logic            busy;
  logic            done;
  logic            sample_valid;
  logic [SELW-1:0] sample_ch;
  logic            sample_bit;
  logic [NCH-1:0]  result;

  modport master (
    output start, abort, mask, y,
    input  s2, s1, s0, busy, done, sample_valid, sample_ch, sample_bit, result
  );

  modport slave (
    input  start, abort, mask, y,
    output s2, s1, s0, busy, done, sample_valid, sample_ch, sample_bit, result
  );

endinterface

// File: rtl/mux_scan_sequencer_lowest_set_bit_8.sv
// Combinational priority encoder: index of the lowest set bit, vld low when no bit is set.
module lowest_set_bit_8
  import mux_scan_sequencer_pkg::*;
(
  input  logic [NCH-1:0]  bits,
  output logic [SELW-1:0] idx,
  output logic            vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Descending walk so the lowest set bit is the last one written.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = SELW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans enabled mux channels in ascending order, holding each select SETTLE cycles before sampling Y.
// Capture k lands SETTLE*k edges after the accepted START; START is ignored while busy, ABORT cancels.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SETTLE = 2
)
(
  input  logic                 clk,
  input  logic                 rstn,
  mux_scan_sequencer_if.slave  bus
);

  localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(SETTLE - 1);

  state_t          state, state_n;
  logic [NCH-1:0]  pending, pending_n;
  logic [SELW-1:0] sel, sel_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [NCH-1:0]  result, result_n;
  logic            busy, busy_n;
  logic            done, done_n;
  logic            smp_vld, smp_vld_n;
  logic [SELW-1:0] smp_ch, smp_ch_n;
  logic            smp_bit, smp_bit_n;

  logic [NCH-1:0]  pend_clr;
  logic [NCH-1:0]  lsb_in;
  logic [SELW-1:0] lsb_idx;
  logic            lsb_vld;

  // One encoder serves both the first select (from MASK) and every following one.
  assign pend_clr = pending & ~(NCH'(1) << sel);
  assign lsb_in   = (state == ST_IDLE) ? bus.mask : pend_clr;

  lowest_set_bit_8 u_lsb (
    .bits (lsb_in),
    .idx  (lsb_idx),
    .vld  (lsb_vld)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      pending <= '0;
      sel     <= '0;
      cnt     <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      smp_vld <= 1'b0;
      smp_ch  <= '0;
      smp_bit <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      sel     <= sel_n;
      cnt     <= cnt_n;
      result  <= result_n;
      busy    <= busy_n;
      done    <= done_n;
      smp_vld <= smp_vld_n;
      smp_ch  <= smp_ch_n;
      smp_bit <= smp_bit_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    sel_n     = sel;
    cnt_n     = cnt;
    result_n  = result;
    busy_n    = busy;
    done_n    = 1'b0;
    smp_vld_n = 1'b0;
    smp_ch_n  = smp_ch;
    smp_bit_n = smp_bit;

    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        sel_n  = '0;
        if (bus.start && !bus.abort) begin
          result_n = '0;
          if (lsb_vld) begin
            pending_n = bus.mask;
            sel_n     = lsb_idx;
            cnt_n     = CNT_RELOAD;
            busy_n    = 1'b1;
            state_n   = ST_SETTLE;
          end else begin
            done_n = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (bus.abort) begin
          pending_n = '0;
          sel_n     = '0;
          cnt_n     = '0;
          busy_n    = 1'b0;
          state_n   = ST_IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNTW'(1);
        end else begin
          result_n[sel] = bus.y;
          pending_n     = pend_clr;
          smp_vld_n     = 1'b1;
          smp_ch_n      = sel;
          smp_bit_n     = bus.y;
          if (lsb_vld) begin
            sel_n = lsb_idx;
            cnt_n = CNT_RELOAD;
          end else begin
            // Completion is folded into the last capture edge rather than spending a cycle in FINISH.
            sel_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end

      default: begin
        sel_n   = '0;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.s2           = sel[2];
  assign bus.s1           = sel[1];
  assign bus.s0           = sel[0];
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.sample_valid = smp_vld;
  assign bus.sample_ch    = smp_ch;
  assign bus.sample_bit   = smp_bit;
  assign bus.result       = result;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE=2 and SETTLE=1) scanning a modelled mux driven from their selects.
module tb_mux_scan_sequencer;

  typedef struct {
    logic [2:0] ch;
    logic       b;
  } smp_t;

  logic       clk;
  logic       rstn;
  logic [7:0] pat1, pat2;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  smp_t sq1[$], sq2[$];
  int   dq1[$], dq2[$];

  logic [2:0] h_sel1, h_sel2;
  int         h_cnt1 = 0, h_cnt2 = 0;

  mux_scan_sequencer_if if1 ();
  mux_scan_sequencer_if if2 ();

  mux_scan_sequencer #(.SETTLE(2)) dut2 (.clk(clk), .rstn(rstn), .bus(if2));
  mux_scan_sequencer #(.SETTLE(1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));

  assign if2.y = pat2[{if2.s2, if2.s1, if2.s0}];
  assign if1.y = pat1[{if1.s2, if1.s1, if1.s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor for the SETTLE=2 instance: sample order/values, select hold time, DONE timing.
  always @(negedge clk) begin
    smp_t e;
    if (!rstn) begin
      h_cnt2 <= 0;
    end else begin
      if (if2.sample_valid) begin
        if (sq2.size() == 0) chk("unexp_sample2", 1, 0);
        else begin
          e = sq2.pop_front();
          chk("sample_ch2", 32'(if2.sample_ch), 32'(e.ch));
          chk("sample_bit2", 32'(if2.sample_bit), 32'(e.b));
        end
        chk("hold_sel2", 32'(h_sel2), 32'(if2.sample_ch));
        chk("hold_len2", h_cnt2, 2);
      end
      if (if2.done) begin
        if (dq2.size() == 0) chk("unexp_done2", 1, 0);
        else chk("done_cyc2", cyc, dq2.pop_front());
      end
      if (!if2.busy) h_cnt2 <= 0;
      else if (if2.sample_valid || h_cnt2 == 0 || {if2.s2, if2.s1, if2.s0} != h_sel2) begin
        h_sel2 <= {if2.s2, if2.s1, if2.s0};
        h_cnt2 <= 1;
      end else h_cnt2 <= h_cnt2 + 1;
    end
  end

  // Same monitor for the SETTLE=1 instance.
  always @(negedge clk) begin
    smp_t e;
    if (!rstn) begin
      h_cnt1 <= 0;
    end else begin
      if (if1.sample_valid) begin
        if (sq1.size() == 0) chk("unexp_sample1", 1, 0);
        else begin
          e = sq1.pop_front();
          chk("sample_ch1", 32'(if1.sample_ch), 32'(e.ch));
          chk("sample_bit1", 32'(if1.sample_bit), 32'(e.b));
        end
        chk("hold_sel1", 32'(h_sel1), 32'(if1.sample_ch));
        chk("hold_len1", h_cnt1, 1);
      end
      if (if1.done) begin
        if (dq1.size() == 0) chk("unexp_done1", 1, 0);
        else chk("done_cyc1", cyc, dq1.pop_front());
      end
      if (!if1.busy) h_cnt1 <= 0;
      else if (if1.sample_valid || h_cnt1 == 0 || {if1.s2, if1.s1, if1.s0} != h_sel1) begin
        h_sel1 <= {if1.s2, if1.s1, if1.s0};
        h_cnt1 <= 1;
      end else h_cnt1 <= h_cnt1 + 1;
    end
  end

  // Called on a falling edge: queues expected captures/DONE time, then pulses START for one edge.
  task automatic launch(input bit d1, input logic [7:0] m);
    logic [7:0] pat;
    smp_t       e;
    int         n;
    int         st;
    st  = d1 ? 1 : 2;
    pat = d1 ? pat1 : pat2;
    n   = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.ch = 3'(i);
        e.b  = pat[i];
        if (d1) sq1.push_back(e); else sq2.push_back(e);
        n++;
      end
    end
    if (d1) begin
      dq1.push_back(cyc + 1 + st * n);
      if1.mask  = m;
      if1.start = 1'b1;
    end else begin
      dq2.push_back(cyc + 1 + st * n);
      if2.mask  = m;
      if2.start = 1'b1;
    end
    @(negedge clk);
    if1.start = 1'b0;
    if2.start = 1'b0;
  endtask

  task automatic wait_done(input bit d1, input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (d1 ? if1.done : if2.done) break;
      @(negedge clk);
    end
    chk(tag, 32'(d1 ? if1.done : if2.done), 1);
    #1;
  endtask

  task automatic outs_zero2(input string tag);
    chk({tag, "_sel"}, 32'({if2.s2, if2.s1, if2.s0}), 0);
    chk({tag, "_busy"}, 32'(if2.busy), 0);
    chk({tag, "_done"}, 32'(if2.done), 0);
    chk({tag, "_svld"}, 32'(if2.sample_valid), 0);
    chk({tag, "_sch"}, 32'(if2.sample_ch), 0);
    chk({tag, "_sbit"}, 32'(if2.sample_bit), 0);
    chk({tag, "_result"}, 32'(if2.result), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int seen;
    rstn = 1'b0;
    pat2 = 8'hA5;
    pat1 = 8'h3C;
    {if1.start, if1.abort, if1.mask} = '0;
    {if2.start, if2.abort, if2.mask} = '0;
    repeat (3) @(negedge clk);
    outs_zero2("reset");
    chk("reset_result1", 32'(if1.result), 0);
    chk("reset_busy1", 32'(if1.busy), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Full scan, SETTLE=2.
    launch(0, 8'hFF);
    chk("full_busy", 32'(if2.busy), 1);
    wait_done(0, "full_done_seen", 40);
    chk("full_result", 32'(if2.result), 32'(pat2));
    chk("full_busy_low", 32'(if2.busy), 0);
    @(negedge clk);
    chk("full_done_pulse", 32'(if2.done), 0);
    chk("full_result_hold", 32'(if2.result), 32'(pat2));

    // Sparse mask: channels 4 and 7 only.
    launch(0, 8'h90);
    wait_done(0, "sparse_done_seen", 20);
    chk("sparse_result", 32'(if2.result), 32'(pat2 & 8'h90));
    @(negedge clk);

    // Empty mask completes immediately without going busy.
    launch(0, 8'h00);
    chk("empty_busy", 32'(if2.busy), 0);
    chk("empty_sel", 32'({if2.s2, if2.s1, if2.s0}), 0);
    wait_done(0, "empty_done_seen", 2);
    chk("empty_result", 32'(if2.result), 0);
    @(negedge clk);

    // Abort after the third capture.
    launch(0, 8'hFF);
    seen = 0;
    for (int i = 0; i < 30 && seen < 3; i++) begin
      if (if2.sample_valid) seen++;
      if (seen < 3) @(negedge clk);
    end
    chk("abort_third_seen", seen, 3);
    if2.abort = 1'b1;
    @(negedge clk);
    if2.abort = 1'b0;
    #1;
    chk("abort_busy", 32'(if2.busy), 0);
    chk("abort_done", 32'(if2.done), 0);
    chk("abort_svld", 32'(if2.sample_valid), 0);
    chk("abort_sel", 32'({if2.s2, if2.s1, if2.s0}), 0);
    chk("abort_result", 32'(if2.result), 32'(pat2 & 8'h07));
    chk("abort_left", sq2.size(), 5);
    sq2.delete();
    dq2.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(if2.done), 0);

    // START during a scan is ignored; DONE timing is checked against the original launch.
    launch(0, 8'hFF);
    repeat (4) @(negedge clk);
    if2.mask  = 8'h01;
    if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    wait_done(0, "restart_done_seen", 40);
    chk("restart_result", 32'(if2.result), 32'(pat2));
    @(negedge clk);

    // Reset mid-scan for one edge, then a fresh full scan.
    launch(0, 8'hFF);
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    outs_zero2("midrst");
    sq2.delete();
    dq2.delete();
    @(negedge clk);
    chk("midrst_no_done", 32'(if2.done), 0);
    launch(0, 8'hFF);
    wait_done(0, "post_rst_done_seen", 40);
    chk("post_rst_result", 32'(if2.result), 32'(pat2));
    @(negedge clk);

    // SETTLE=1 instance: capture on every edge.
    launch(1, 8'hFF);
    wait_done(1, "s1_done_seen", 20);
    chk("s1_result", 32'(if1.result), 32'(pat1));
    chk("s1_busy_low", 32'(if1.busy), 0);
    repeat (2) @(negedge clk);

    chk("sb_samples2_empty", sq2.size(), 0);
    chk("sb_done2_empty", dq2.size(), 0);
    chk("sb_samples1_empty", sq1.size(), 0);
    chk("sb_done1_empty", dq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
